// File: rtl/sound_bus_pkg.sv
// rtl/sound_bus_pkg.sv - shared types and default timing for the sound board POKEY bus
package sound_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        CPU_HOLD = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_AUX = 1'b1
    } gnt_t;

    localparam int DEF_NCHIP  = 3;
    localparam int DEF_DIV    = 10;
    localparam int DEF_E_HI   = 6;
    localparam int DEF_ACK_AT = 8;

endpackage

// File: rtl/e_phase_gen.sv
// rtl/e_phase_gen.sv - free-running E-period divider with registered E and period strobes
module e_phase_gen
    import sound_bus_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int E_HI   = DEF_E_HI,
    parameter int ACK_AT = DEF_ACK_AT
) (
    input  logic cl,
    input  logic rst_n,
    output logic E,
    output logic period_end,
    output logic ack_point
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE_ACK = CW'(ACK_AT - 1);
    localparam logic [CW-1:0] E_START = CW'(E_HI);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // ack_point leads by one cycle so registered acks are visible while cnt==ACK_AT
    assign period_end = (cnt == LAST);
    assign ack_point  = (cnt == PRE_ACK);
    assign cnt_nxt    = period_end ? '0 : cnt + CW'(1);

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            E   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            E   <= (cnt_nxt >= E_START);
        end
    end

endmodule

// File: rtl/pokey_bus_arbiter.sv
// rtl/pokey_bus_arbiter.sv - one-access-per-E-period arbiter between the 68000 and the aux port
module pokey_bus_arbiter
    import sound_bus_pkg::*;
#(
    parameter int NCHIP  = DEF_NCHIP,
    parameter int DIV    = DEF_DIV,
    parameter int E_HI   = DEF_E_HI,
    parameter int ACK_AT = DEF_ACK_AT
) (
    input  logic               cl,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic [NCHIP-1:0]   cpu_sel,
    input  logic               cpu_we,
    input  logic [3:0]         cpu_ad,
    input  logic [7:0]         cpu_wd,
    output logic [7:0]         cpu_rd,
    output logic               cpu_dtack,
    input  logic               aux_req,
    input  logic [NCHIP-1:0]   aux_sel,
    input  logic               aux_we,
    input  logic [3:0]         aux_ad,
    input  logic [7:0]         aux_wd,
    output logic [7:0]         aux_rd,
    output logic               aux_ack,
    output logic               E,
    output logic [NCHIP-1:0]   chip_cs,
    output logic               chip_we,
    output logic [3:0]         chip_ad,
    output logic [7:0]         chip_wd,
    input  logic [8*NCHIP-1:0] chip_rd
);
    state_t     state;
    gnt_t       gnt;
    gnt_t       last_gnt;
    logic       period_end;
    logic       ack_point;
    logic       cpu_valid;
    logic       aux_valid;
    logic       pick_aux;
    logic [7:0] sel_rd;

    function automatic logic [NCHIP-1:0] first_sel(input logic [NCHIP-1:0] s);
        return s & (~s + NCHIP'(1));
    endfunction

    e_phase_gen #(
        .DIV    (DIV),
        .E_HI   (E_HI),
        .ACK_AT (ACK_AT)
    ) u_phase (
        .cl         (cl),
        .rst_n      (rst_n),
        .E          (E),
        .period_end (period_end),
        .ack_point  (ack_point)
    );

    assign cpu_valid = cpu_req & (|cpu_sel);
    assign aux_valid = aux_req & (|aux_sel);
    // On a tie the requester that did not win last time goes first
    assign pick_aux  = aux_valid & (~cpu_valid | (last_gnt == GNT_CPU));

    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < NCHIP; i++) begin
            if (chip_cs[i]) begin
                sel_rd = sel_rd | chip_rd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_CPU;
            last_gnt  <= GNT_AUX;
            chip_cs   <= '0;
            chip_we   <= 1'b0;
            chip_ad   <= '0;
            chip_wd   <= '0;
            cpu_rd    <= '0;
            cpu_dtack <= 1'b0;
            aux_rd    <= '0;
            aux_ack   <= 1'b0;
        end else begin
            aux_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (period_end && (cpu_valid || aux_valid)) begin
                        state <= ACCESS;
                        if (pick_aux) begin
                            gnt     <= GNT_AUX;
                            chip_cs <= first_sel(aux_sel);
                            chip_we <= aux_we;
                            chip_ad <= aux_ad;
                            chip_wd <= aux_wd;
                        end else begin
                            gnt     <= GNT_CPU;
                            chip_cs <= first_sel(cpu_sel);
                            chip_we <= cpu_we;
                            chip_ad <= cpu_ad;
                            chip_wd <= cpu_wd;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_point) begin
                        if (!chip_we) begin
                            if (gnt == GNT_CPU) begin
                                cpu_rd <= sel_rd;
                            end else begin
                                aux_rd <= sel_rd;
                            end
                        end
                        // An aborted CPU cycle still runs on the chip but gets no DTACK
                        if (gnt == GNT_CPU) begin
                            cpu_dtack <= cpu_req;
                        end else begin
                            aux_ack <= 1'b1;
                        end
                        last_gnt <= gnt;
                    end else if (!cpu_req) begin
                        cpu_dtack <= 1'b0;
                    end
                    if (period_end) begin
                        chip_cs <= '0;
                        chip_we <= 1'b0;
                        if (gnt == GNT_CPU && cpu_dtack && cpu_req) begin
                            state <= CPU_HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                CPU_HOLD: begin
                    if (!cpu_req) begin
                        cpu_dtack <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// tb/tb_pokey_bus_arbiter.sv - self-checking bench for pokey_bus_arbiter
module tb_pokey_bus_arbiter;
    localparam int NCHIP  = 3;
    localparam int DIV    = 10;
    localparam int E_HI   = 6;
    localparam int ACK_AT = 8;

    logic        cl = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [2:0]  cpu_sel = '0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_ad = '0;
    logic [7:0]  cpu_wd = '0;
    logic [7:0]  cpu_rd;
    logic        cpu_dtack;
    logic        aux_req = 1'b0;
    logic [2:0]  aux_sel = '0;
    logic        aux_we = 1'b0;
    logic [3:0]  aux_ad = '0;
    logic [7:0]  aux_wd = '0;
    logic [7:0]  aux_rd;
    logic        aux_ack;
    logic        e_out;
    logic [2:0]  chip_cs;
    logic        chip_we;
    logic [3:0]  chip_ad;
    logic [7:0]  chip_wd;
    logic [23:0] chip_rd = '0;

    int n_cmp = 0;
    int n_err = 0;
    int tcnt;
    bit model_on = 1'b0;

    pokey_bus_arbiter #(
        .NCHIP(NCHIP), .DIV(DIV), .E_HI(E_HI), .ACK_AT(ACK_AT)
    ) dut (
        .cl(cl), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_ad(cpu_ad),
        .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_dtack(cpu_dtack),
        .aux_req(aux_req), .aux_sel(aux_sel), .aux_we(aux_we), .aux_ad(aux_ad),
        .aux_wd(aux_wd), .aux_rd(aux_rd), .aux_ack(aux_ack),
        .E(e_out), .chip_cs(chip_cs), .chip_we(chip_we), .chip_ad(chip_ad),
        .chip_wd(chip_wd), .chip_rd(chip_rd)
    );

    always #5 cl = ~cl;

    // Period position as the bench expects it: cycles since reset, modulo DIV
    always @(posedge cl or negedge rst_n) begin
        if (!rst_n) tcnt <= 0;
        else        tcnt <= (tcnt + 1) % DIV;
    end

    typedef struct {
        logic       is_aux;
        logic [2:0] sel;
        logic       we;
        logic [3:0] ad;
        logic [7:0] wd;
        logic [7:0] rdv;
        logic [2:0] exp_cs;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[6];

    // Reference model: transaction view of the bus, stepped once per clock edge
    logic [2:0] x_cs;
    logic       x_we, x_dtack, x_aux_ack, x_e;
    logic [3:0] x_ad;
    logic [7:0] x_wd, x_cpu_rd, x_aux_rd;
    int         m_cnt;
    bit         m_busy, m_hold, m_who_aux, m_last_aux;

    task m_reset();
        x_cs = '0; x_we = 0; x_dtack = 0; x_aux_ack = 0; x_e = 0;
        x_ad = '0; x_wd = '0; x_cpu_rd = '0; x_aux_rd = '0;
        m_cnt = 0; m_busy = 0; m_hold = 0; m_who_aux = 0; m_last_aux = 1;
    endtask

    task m_edge();
        bit cv, av;
        int idx;
        logic [2:0] s;
        logic [7:0] rd;
        cv = cpu_req && (cpu_sel != 0);
        av = aux_req && (aux_sel != 0);
        x_aux_ack = 0;
        if (m_busy) begin
            if (m_cnt == ACK_AT - 1) begin
                idx = 0;
                for (int i = NCHIP - 1; i >= 0; i--) if (x_cs[i]) idx = i;
                rd = 8'(chip_rd >> (8 * idx));
                if (!x_we) begin
                    if (m_who_aux) x_aux_rd = rd;
                    else           x_cpu_rd = rd;
                end
                if (m_who_aux) x_aux_ack = 1;
                else           x_dtack = cpu_req;
                m_last_aux = m_who_aux;
            end else if (!cpu_req) begin
                x_dtack = 0;
            end
            if (m_cnt == DIV - 1) begin
                m_busy = 0;
                m_hold = !m_who_aux && x_dtack;
                x_cs = '0;
                x_we = 0;
            end
        end else if (m_hold) begin
            if (!cpu_req) begin
                x_dtack = 0;
                m_hold = 0;
            end
        end else if (m_cnt == DIV - 1 && (cv || av)) begin
            m_who_aux = av && (!cv || !m_last_aux);
            s = m_who_aux ? aux_sel : cpu_sel;
            x_cs = '0;
            for (int i = NCHIP - 1; i >= 0; i--) if (s[i]) x_cs = 3'(1 << i);
            x_we = m_who_aux ? aux_we : cpu_we;
            x_ad = m_who_aux ? aux_ad : cpu_ad;
            x_wd = m_who_aux ? aux_wd : cpu_wd;
            m_busy = 1;
        end
        m_cnt = (m_cnt + 1) % DIV;
        x_e = (m_cnt >= E_HI);
    endtask

    always @(posedge cl) begin
        if (!model_on) m_reset();
        else           m_edge();
    end

    function automatic logic [34:0] dut_out();
        return {e_out, chip_cs, chip_we, chip_ad, chip_wd, cpu_rd, cpu_dtack, aux_rd, aux_ack};
    endfunction

    function automatic logic [34:0] model_out();
        return {x_e, x_cs, x_we, x_ad, x_wd, x_cpu_rd, x_dtack, x_aux_rd, x_aux_ack};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge cl);
    endtask

    task automatic wait_cnt(input int n);
        for (int i = 0; i < 2 * DIV && tcnt != n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge cl);
        rst_n = 0;
        #1 check("reset_outputs", 64'(dut_out()), 64'd0);
        @(negedge cl);
        rst_n = 1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b010, 1'b0, 4'hA, 8'h00, 8'h5C, 3'b010, 8'h5C};
        vecs[1] = '{1'b1, 3'b100, 1'b1, 4'h8, 8'h3F, 8'h00, 3'b100, 8'h00};
        vecs[2] = '{1'b0, 3'b110, 1'b0, 4'h3, 8'h00, 8'hA7, 3'b010, 8'hA7};
        vecs[3] = '{1'b1, 3'b111, 1'b0, 4'hF, 8'h00, 8'h91, 3'b001, 8'h91};
        vecs[4] = '{1'b0, 3'b001, 1'b1, 4'h5, 8'hE4, 8'h00, 3'b001, 8'hA7};
        vecs[5] = '{1'b1, 3'b100, 1'b0, 4'h1, 8'h00, 8'h6D, 3'b100, 8'h6D};

        // Idle after reset: E pattern only
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            check("idle_e", 64'(e_out), 64'(tcnt >= E_HI));
            check("idle_quiet", {61'd0, chip_cs | {cpu_dtack, aux_ack, 1'b0}}, 64'd0);
        end

        // Single transactions from the table
        for (int v = 0; v < 6; v++) begin
            int  n;
            bit  got;
            wait_cnt(2);
            for (int i = 0; i < NCHIP; i++)
                chip_rd[8*i +: 8] = vecs[v].exp_cs[i] ? vecs[v].rdv : ~vecs[v].rdv;
            if (vecs[v].is_aux) begin
                aux_sel = vecs[v].sel; aux_we = vecs[v].we; aux_ad = vecs[v].ad;
                aux_wd = vecs[v].wd; aux_req = 1;
            end else begin
                cpu_sel = vecs[v].sel; cpu_we = vecs[v].we; cpu_ad = vecs[v].ad;
                cpu_wd = vecs[v].wd; cpu_req = 1;
            end
            n = 0;
            got = 0;
            while (n < 3 * DIV && !got) begin
                tick();
                n++;
                got = vecs[v].is_aux ? aux_ack : cpu_dtack;
            end
            check("vec_latency", 64'(n), 64'd16);
            check("vec_ack_cnt", 64'(tcnt), 64'(ACK_AT));
            check("vec_cs", 64'(chip_cs), 64'(vecs[v].exp_cs));
            check("vec_we", 64'(chip_we), 64'(vecs[v].we));
            check("vec_ad", 64'(chip_ad), 64'(vecs[v].ad));
            check("vec_wd", 64'(chip_wd), 64'(vecs[v].wd));
            check("vec_rd", 64'(vecs[v].is_aux ? aux_rd : cpu_rd), 64'(vecs[v].exp_rd));
            aux_req = 0;
            cpu_req = 0;
            tick();
            check("vec_ack_fall", 64'(vecs[v].is_aux ? aux_ack : cpu_dtack), 64'd0);
            check("vec_cs_held", 64'(chip_cs), 64'(vecs[v].exp_cs));
            tick();
            check("vec_cs_drop", 64'({chip_cs, chip_we}), 64'd0);
        end

        // Request with empty select is never granted
        cpu_sel = 3'b000; cpu_req = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("nosel_cs", 64'({chip_cs, cpu_dtack}), 64'd0);
        end
        cpu_req = 0;

        // Tie at the first period end after reset, then strict alternation
        begin
            int  ngr;
            int  first_t;
            bit  exp_cpu;
            cpu_sel = 3'b001; cpu_we = 0; cpu_ad = 4'h4;
            aux_sel = 3'b100; aux_we = 1; aux_ad = 4'h9; aux_wd = 8'h12;
            cpu_req = 1; aux_req = 1;
            do_reset();
            ngr = 0; first_t = -1; exp_cpu = 1;
            for (int t = 1; t <= 80; t++) begin
                tick();
                if (tcnt == 0 && chip_cs != 0) begin
                    check("alt_grant", 64'(chip_cs), exp_cpu ? 64'h1 : 64'h4);
                    if (first_t < 0) first_t = t;
                    exp_cpu = !exp_cpu;
                    ngr++;
                end
                if (cpu_req && cpu_dtack) cpu_req = 0;
                else if (!cpu_req) cpu_req = 1;
            end
            check("alt_first_t", 64'(first_t), 64'd10);
            check("alt_count", 64'(ngr), 64'd4);
            cpu_req = 0; aux_req = 0;
            repeat (2 * DIV) tick();
        end

        // Aborted CPU read: access completes, no DTACK, arbitration still advances
        wait_cnt(2);
        chip_rd = {8'h3C, 8'hC3, 8'h3C};
        cpu_sel = 3'b010; cpu_we = 0; cpu_ad = 4'h7; cpu_req = 1;
        wait_cnt(9);
        tick();
        check("abort_cs", 64'(chip_cs), 64'h2);
        wait_cnt(3);
        cpu_req = 0;
        for (int i = 4; i < DIV; i++) begin
            tick();
            check("abort_no_dtack", 64'(cpu_dtack), 64'd0);
        end
        check("abort_cs_span", 64'(chip_cs), 64'h2);
        tick();
        check("abort_cs_drop", 64'(chip_cs), 64'd0);
        check("abort_rd", 64'(cpu_rd), 64'hC3);
        aux_sel = 3'b001; aux_we = 1; aux_ad = 4'h0; aux_wd = 8'h77;
        cpu_sel = 3'b010; cpu_req = 1; aux_req = 1;
        wait_cnt(9);
        tick();
        check("abort_next_aux", 64'(chip_cs), 64'h1);
        cpu_req = 0;
        for (int i = 0; i < 3 * DIV && !aux_ack; i++) tick();
        check("abort_aux_ack", 64'(aux_ack), 64'd1);
        aux_req = 0;
        repeat (DIV) tick();

        // Asynchronous reset in the middle of an access
        cpu_sel = 3'b001; cpu_we = 1; cpu_ad = 4'h2; cpu_wd = 8'h55;
        wait_cnt(2);
        cpu_req = 1;
        wait_cnt(9);
        tick();
        check("mid_rst_pre_cs", 64'(chip_cs), 64'h1);
        wait_cnt(5);
        #2 rst_n = 0;
        #1 check("mid_rst_cs", 64'(chip_cs), 64'd0);
        check("mid_rst_e_dtack", 64'({e_out, cpu_dtack}), 64'd0);
        tick();
        rst_n = 1;
        repeat (DIV - 1) tick();
        check("mid_rst_no_early", 64'(chip_cs), 64'd0);
        tick();
        check("mid_rst_regrant", 64'(chip_cs), 64'h1);
        for (int i = 0; i < 3 * DIV && !cpu_dtack; i++) tick();
        check("mid_rst_dtack", 64'(cpu_dtack), 64'd1);
        cpu_req = 0;
        repeat (DIV) tick();

        // Randomized traffic against the reference model
        @(negedge cl);
        rst_n = 0;
        @(negedge cl);
        rst_n = 1;
        model_on = 1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            check("model", 64'(dut_out()), 64'(model_out()));
            chip_rd = 24'($urandom);
            if (!cpu_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    cpu_sel = 3'($urandom_range(1, 7)); cpu_we = 1'($urandom);
                    cpu_ad = 4'($urandom); cpu_wd = 8'($urandom); cpu_req = 1;
                end
            end else if (cpu_dtack) begin
                if ($urandom_range(0, 1) == 0) cpu_req = 0;
            end else if ($urandom_range(0, 39) == 0) begin
                cpu_req = 0;
            end
            if (aux_ack) begin
                if ($urandom_range(0, 7) != 0) aux_req = 0;
            end else if (!aux_req && $urandom_range(0, 3) == 0) begin
                aux_sel = 3'($urandom_range(1, 7)); aux_we = 1'($urandom);
                aux_ad = 4'($urandom); aux_wd = 8'($urandom); aux_req = 1;
            end
        end
        model_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
